ntt_ctrl: RTL and testbench

- Sequencer for the 256-entry dual-port coefficient BRAM during an in-place ML-KEM NTT or inverse NTT.
- Issues butterfly operand pairs (j, j+len) on BRAM ports A/B, one pair per cycle, and drives the zeta index and valid to the external butterfly unit.
- Delays the pair addresses to match butterfly latency, then issues the write-back, and drains the pipeline between layers.
- Carries no coefficient data: butterfly outputs connect to BRAM din_a/din_b externally.

---
 rtl/ntt_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ntt_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_ctrl.sv
// Address and control sequencer for an in-place ML-KEM NTT / inverse NTT
// over a 256-entry dual-port coefficient BRAM with a pipelined butterfly.
module ntt_ctrl #(
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8,
    parameter int BF_LAT     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  inv,
    output logic                  busy,
    output logic                  done,
    output logic                  en_a,
    output logic                  en_b,
    output logic [ADDR_WIDTH-1:0] raddr_a,
    output logic [ADDR_WIDTH-1:0] raddr_b,
    output logic                  we_a,
    output logic                  we_b,
    output logic [ADDR_WIDTH-1:0] waddr_a,
    output logic [ADDR_WIDTH-1:0] waddr_b,
    output logic                  bf_valid,
    output logic                  bf_inv,
    output logic [6:0]            zeta_idx
);

    localparam int NPAIR = DEPTH / 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e state_q, state_d;
    logic   inv_q, inv_d;
    logic [2:0] layer_q, layer_d;
    logic [6:0] cnt_q, cnt_d;
    logic [3:0] dcnt_q, dcnt_d;
    logic [6:0] zeta_q, zeta_d;
    logic [BF_LAT:0] vld_q;
    logic [ADDR_WIDTH-1:0] pa_q [BF_LAT+1];
    logic [ADDR_WIDTH-1:0] pb_q [BF_LAT+1];

    logic                  issue;
    logic [2:0]            shift;
    logic [ADDR_WIDTH-1:0] len;
    logic [ADDR_WIDTH-1:0] lo_mask;
    logic [ADDR_WIDTH-1:0] cnt_ext;
    logic [ADDR_WIDTH-1:0] group;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [ADDR_WIDTH-1:0] k_fwd;
    logic [ADDR_WIDTH-1:0] k_inv;

    assign issue = (state_q == S_ISSUE);

    // Pair (j, j+len): insert a zero bit at position log2(len) of bf_cnt.
    always_comb begin
        shift   = inv_q ? (layer_q + 3'd1) : (3'd7 - layer_q);
        len     = ADDR_WIDTH'(1) << shift;
        lo_mask = len - ADDR_WIDTH'(1);
        cnt_ext = ADDR_WIDTH'(cnt_q);
        group   = cnt_ext >> shift;
        addr_a  = (cnt_ext & lo_mask) | ((cnt_ext & ~lo_mask) << 1);
        addr_b  = addr_a | len;
        k_fwd   = (ADDR_WIDTH'(1) << layer_q) + group;
        k_inv   = (ADDR_WIDTH'(128) >> layer_q) - ADDR_WIDTH'(1) - group;
        zeta_d  = 7'(inv_q ? k_inv : k_fwd);
    end

    always_comb begin
        state_d = state_q;
        inv_d   = inv_q;
        layer_d = layer_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    inv_d   = inv;
                    layer_d = 3'd0;
                    cnt_d   = 7'd0;
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == 7'(NPAIR - 1)) begin
                    state_d = S_DRAIN;
                    dcnt_d  = 4'd0;
                end
            end
            S_DRAIN: begin
                dcnt_d = dcnt_q + 4'd1;
                if (dcnt_q == 4'(BF_LAT)) begin
                    if (layer_q == 3'd6) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        layer_d = layer_q + 3'd1;
                        cnt_d   = 7'd0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            inv_q   <= 1'b0;
            layer_q <= 3'd0;
            cnt_q   <= 7'd0;
            dcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            inv_q   <= inv_d;
            layer_q <= layer_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Read addresses ride along with the butterfly to become write addresses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            zeta_q <= 7'd0;
            for (int i = 0; i <= BF_LAT; i++) begin
                pa_q[i] <= '0;
                pb_q[i] <= '0;
            end
        end else begin
            vld_q <= {vld_q[BF_LAT-1:0], issue};
            if (issue) begin
                zeta_q  <= zeta_d;
                pa_q[0] <= addr_a;
                pb_q[0] <= addr_b;
            end
            for (int i = 1; i <= BF_LAT; i++) begin
                pa_q[i] <= pa_q[i-1];
                pb_q[i] <= pb_q[i-1];
            end
        end
    end

    assign busy     = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done     = (state_q == S_DONE);
    assign raddr_a  = issue ? addr_a : '0;
    assign raddr_b  = issue ? addr_b : '0;
    assign we_a     = vld_q[BF_LAT];
    assign we_b     = vld_q[BF_LAT];
    assign en_a     = issue | vld_q[BF_LAT];
    assign en_b     = issue | vld_q[BF_LAT];
    assign waddr_a  = pa_q[BF_LAT];
    assign waddr_b  = pb_q[BF_LAT];
    assign bf_valid = vld_q[0];
    assign bf_inv   = inv_q;
    assign zeta_idx = zeta_q;

endmodule

// File: tb/tb_ntt_ctrl.sv
// Bench for ntt_ctrl: BRAM + butterfly model driven by the DUT, scoreboards
// for read pairs / write-back, and a reference FIPS 203 NTT for the data.
module tb_ntt_ctrl;
    localparam int BF_LAT = 4;
    localparam int Q      = 3329;
    localparam int LAT    = 1 + 7 * (129 + BF_LAT);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       inv = 1'b0;
    logic       busy, done, en_a, en_b, we_a, we_b, bf_valid, bf_inv;
    logic [7:0] raddr_a, raddr_b, waddr_a, waddr_b;
    logic [6:0] zeta_idx;

    always #5 clk = ~clk;

    ntt_ctrl #(.DEPTH(256), .ADDR_WIDTH(8), .BF_LAT(BF_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .inv(inv),
        .busy(busy), .done(done), .en_a(en_a), .en_b(en_b),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .we_a(we_a), .we_b(we_b),
        .waddr_a(waddr_a), .waddr_b(waddr_b), .bf_valid(bf_valid),
        .bf_inv(bf_inv), .zeta_idx(zeta_idx)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int s_run = 0;
    bit mon_on = 1'b0;
    bit ld = 1'b0;

    int zetas [128];
    int mem [256];
    int img [256];
    int gold [256];
    int dout_a, dout_b;

    typedef struct { int a; int b; int k; } rd_t;
    typedef struct { int a; int b; int c; } wr_t;
    rd_t rdq [$];
    wr_t wrq [$];
    int  bfq_a [$];
    int  bfq_b [$];

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM with registered read plus a behavioural butterfly of depth BF_LAT.
    always @(posedge clk) begin
        int a, b, z, t, ra, rb;
        if (en_a) dout_a <= mem[raddr_a];
        if (en_b) dout_b <= mem[raddr_b];
        if (rst) begin
            bfq_a.delete();
            bfq_b.delete();
        end else begin
            if (bf_valid) begin
                a = dout_a;
                b = dout_b;
                z = zetas[int'(zeta_idx)];
                if (!bf_inv) begin
                    t  = (z * b) % Q;
                    ra = (a + t) % Q;
                    rb = (a - t + Q) % Q;
                end else begin
                    ra = (a + b) % Q;
                    rb = (z * ((b - a + Q) % Q)) % Q;
                end
                bfq_a.push_back(ra);
                bfq_b.push_back(rb);
            end
            if (we_a && bfq_a.size() > 0) mem[waddr_a] <= bfq_a.pop_front();
            if (we_b && bfq_b.size() > 0) mem[waddr_b] <= bfq_b.pop_front();
        end
        if (ld) for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end

    int  p_ra = 0, p_rb = 0, p_wa = 0, p_wb = 0;
    bit  p_we = 1'b0, p_en = 1'b0, p_rdonly = 1'b0;
    rd_t er;
    wr_t ew;

    always @(negedge clk) begin
        if (mon_on) begin
            if (p_rdonly) begin
                total++;
                assert (bf_valid === 1'b1) else begin
                    bad++;
                    $error("FAIL rd_no_valid cyc=%0d got=%b exp=1", cyc, bf_valid);
                end
            end
            if (bf_valid) begin
                total++;
                assert (rdq.size() > 0) else begin
                    bad++;
                    $error("FAIL rd_extra cyc=%0d got=(%0d,%0d) exp=none", cyc, p_ra, p_rb);
                end
                if (rdq.size() > 0) begin
                    er = rdq.pop_front();
                    total++;
                    assert (p_ra == er.a && p_rb == er.b && int'(zeta_idx) == er.k && p_en)
                    else begin
                        bad++;
                        $error("FAIL rd_pair cyc=%0d got=(%0d,%0d,k%0d) exp=(%0d,%0d,k%0d)",
                               cyc, p_ra, p_rb, zeta_idx, er.a, er.b, er.k);
                    end
                end
                total++;
                assert (!(p_we && (p_wa == p_ra || p_wa == p_rb || p_wb == p_ra || p_wb == p_rb)))
                else begin
                    bad++;
                    $error("FAIL raw cyc=%0d got=w(%0d,%0d) r(%0d,%0d) exp=disjoint",
                           cyc, p_wa, p_wb, p_ra, p_rb);
                end
                wrq.push_back('{p_ra, p_rb, cyc});
            end
            if (we_a || we_b) begin
                total++;
                assert (wrq.size() > 0 && we_a === we_b) else begin
                    bad++;
                    $error("FAIL wr_extra cyc=%0d got=we(%b,%b) exp=pending", cyc, we_a, we_b);
                end
                if (wrq.size() > 0) begin
                    ew = wrq.pop_front();
                    total++;
                    assert (int'(waddr_a) == ew.a && int'(waddr_b) == ew.b && cyc == ew.c + BF_LAT)
                    else begin
                        bad++;
                        $error("FAIL wr cyc=%0d got=(%0d,%0d) exp=(%0d,%0d)@%0d",
                               cyc, waddr_a, waddr_b, ew.a, ew.b, ew.c + BF_LAT);
                    end
                end
            end
            if (done) begin
                total++;
                assert (cyc == s_run + LAT && busy === 1'b0) else begin
                    bad++;
                    $error("FAIL done_pulse got=%0d/busy%b exp=%0d/busy0", cyc, busy, s_run + LAT);
                end
            end
        end
        p_ra = int'(raddr_a);
        p_rb = int'(raddr_b);
        p_wa = int'(waddr_a);
        p_wb = int'(waddr_b);
        p_we = we_a;
        p_en = en_a & en_b;
        p_rdonly = en_a & ~we_a;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic at_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    function automatic int bitrev7(input int k);
        int r = 0;
        for (int i = 0; i < 7; i++) r |= ((k >> i) & 1) << (6 - i);
        return r;
    endfunction

    // Reference transform in the FIPS 203 loop order; also queues read pairs.
    function automatic void golden(input bit m);
        int k, t, z;
        if (!m) begin
            k = 1;
            for (int len = 128; len >= 2; len /= 2)
                for (int st = 0; st < 256; st += 2 * len) begin
                    z = zetas[k];
                    for (int j = st; j < st + len; j++) begin
                        rdq.push_back('{j, j + len, k});
                        t = (z * gold[j + len]) % Q;
                        gold[j + len] = (gold[j] - t + Q) % Q;
                        gold[j] = (gold[j] + t) % Q;
                    end
                    k++;
                end
        end else begin
            k = 127;
            for (int len = 2; len <= 128; len *= 2)
                for (int st = 0; st < 256; st += 2 * len) begin
                    z = zetas[k];
                    for (int j = st; j < st + len; j++) begin
                        rdq.push_back('{j, j + len, k});
                        t = gold[j];
                        gold[j] = (t + gold[j + len]) % Q;
                        gold[j + len] = (z * ((gold[j + len] - t + Q) % Q)) % Q;
                    end
                    k--;
                end
        end
    endfunction

    task automatic load(input bit m);
        for (int i = 0; i < 256; i++) begin
            img[i] = $urandom_range(0, Q - 1);
            gold[i] = img[i];
        end
        rdq.delete();
        wrq.delete();
        golden(m);
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic launch(input bit m);
        inv = m;
        start = 1'b1;
        s_run = cyc;
        mon_on = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_run();
        while (done !== 1'b1 && cyc < s_run + LAT + 200) @(negedge clk);
        chk("done_cyc", cyc, s_run + LAT);
        @(negedge clk);
        chk("idle_busy", int'({busy, done}), 0);
        chk("rdq_left", rdq.size(), 0);
        chk("wrq_left", wrq.size(), 0);
        mon_on = 1'b0;
        for (int i = 0; i < 256; i++) chk($sformatf("coef%0d", i), mem[i], gold[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int z;
        for (int k = 0; k < 128; k++) begin
            z = 1;
            for (int e = 0; e < bitrev7(k); e++) z = (z * 17) % Q;
            zetas[k] = z;
        end

        repeat (3) @(negedge clk);
        chk("rst_ctl", int'({busy, done, en_a, en_b, we_a, we_b, bf_valid, bf_inv}), 0);
        chk("rst_addr", int'({raddr_a, raddr_b, waddr_a, waddr_b}), 0);
        chk("rst_zeta", int'(zeta_idx), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        load(1'b0);
        launch(1'b0);
        at_cyc(s_run + 1);
        chk("f_first_a", int'(raddr_a), 0);
        chk("f_first_b", int'(raddr_b), 128);
        chk("f_first_en", int'({en_a, en_b}), 3);
        at_cyc(s_run + 2);
        chk("f_first_valid", int'(bf_valid), 1);
        chk("f_first_k", int'(zeta_idx), 1);
        at_cyc(s_run + 6);
        chk("f_first_we", int'({we_a, we_b}), 3);
        chk("f_first_wa", int'(waddr_a), 0);
        chk("f_first_wb", int'(waddr_b), 128);
        at_cyc(s_run + 50);
        start = 1'b1;
        inv = 1'b1;
        @(negedge clk);
        start = 1'b0;
        at_cyc(s_run + 128);
        chk("f_last_a", int'(raddr_a), 127);
        chk("f_last_b", int'(raddr_b), 255);
        at_cyc(s_run + 130);
        chk("f_drain_novalid", int'(bf_valid), 0);
        inv = 1'b0;
        at_cyc(s_run + 134);
        chk("f_l1_novalid", int'(bf_valid), 0);
        chk("f_l1_a", int'(raddr_a), 0);
        chk("f_l1_b", int'(raddr_b), 64);
        at_cyc(s_run + 135);
        chk("f_l1_k", int'(zeta_idx), 2);
        at_cyc(s_run + 198);
        chk("f_l1_64", int'({raddr_a, raddr_b}), (128 << 8) | 192);
        at_cyc(s_run + 199);
        chk("f_l1_64k", int'(zeta_idx), 3);
        at_cyc(s_run + 799);
        chk("f_l6_0", int'({raddr_a, raddr_b}), (0 << 8) | 2);
        at_cyc(s_run + 800);
        chk("f_l6_1", int'({raddr_a, raddr_b}), (1 << 8) | 3);
        chk("f_l6_k0", int'(zeta_idx), 64);
        at_cyc(s_run + 801);
        chk("f_l6_2", int'({raddr_a, raddr_b}), (4 << 8) | 6);
        at_cyc(s_run + 802);
        chk("f_l6_k2", int'(zeta_idx), 65);
        finish_run();

        load(1'b1);
        launch(1'b1);
        at_cyc(s_run + 1);
        chk("i_first", int'({raddr_a, raddr_b}), (0 << 8) | 2);
        at_cyc(s_run + 2);
        chk("i_first_k", int'(zeta_idx), 127);
        chk("i_binv", int'(bf_inv), 1);
        inv = 1'b0;
        at_cyc(s_run + 64);
        chk("i_cnt63", int'({raddr_a, raddr_b}), (125 << 8) | 127);
        at_cyc(s_run + 65);
        chk("i_cnt63_k", int'(zeta_idx), 96);
        at_cyc(s_run + 127);
        chk("i_cnt126", int'({raddr_a, raddr_b}), (252 << 8) | 254);
        at_cyc(s_run + 128);
        chk("i_cnt126_k", int'(zeta_idx), 64);
        at_cyc(s_run + 799);
        chk("i_l6", int'({raddr_a, raddr_b}), (0 << 8) | 128);
        at_cyc(s_run + 800);
        chk("i_l6_k", int'(zeta_idx), 1);
        finish_run();

        load(1'b0);
        launch(1'b0);
        at_cyc(s_run + 1 + 3 * 133 + 20);
        mon_on = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ctl", int'({busy, done, en_a, en_b, we_a, we_b, bf_valid}), 0);
        chk("mid_rst_addr", int'({raddr_a, raddr_b, waddr_a, waddr_b}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", int'({busy, done, en_a, we_a}), 0);
        load(1'b0);
        launch(1'b0);
        finish_run();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
